addsub_pipe: RTL and testbench
==============================

Name: addsub_pipe

Overview:
- Parametrised, pipelined two's-complement adder/subtractor; successor to the 4-bit ripple add/sub block.
- The operand width is split into CHUNK-bit ripple slices, with one register stage per slice, so carry propagates across clock cycles instead of across one long chain.
- Adds valid/ready handshakes on both sides, backpressure, status flags and optional signed saturation.
- Sits between operand sources and the ALU result mux in datapaths wider than 4 bits.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of CHUNK, and WIDTH >= 2.
- CHUNK, 4, bits per pipeline slice. NSTAGE = WIDTH/CHUNK, which is also the latency in cycles.
- SAT, 0, 1 = clamp the signed result on overflow; 0 = wrap.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts operand beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- ctrl  in  1  0 = A+B, 1 = A-B (A + ~B + 1).
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- s  out  WIDTH  sum/difference (saturated if SAT=1 and ovf).
- c_out  out  1  carry out of MSB (for subtract: 1 = no borrow, A >= B unsigned).
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  out  1  s == 0 (evaluated after saturation).
- neg  out  1  s[WIDTH-1] (after saturation).

Behaviour:
- Global advance enable: en = !out_valid || out_ready. in_ready = en, combinational.
- When en=1, every stage register loads from its predecessor. When en=0, every stage holds, including bubbles.
- A beat is accepted when in_valid && in_ready.
- Stage 0 captures:
  - the low CHUNK bits of a + (b ^ {WIDTH{ctrl}}) + ctrl;
  - the carry out of that slice;
  - the upper operand bits, already inverted for subtract;
  - valid = in_valid.
- Stage k (1..NSTAGE-1) adds slice bits [k*CHUNK +: CHUNK] with the carry from stage k-1. It forwards all completed lower bits and the remaining upper operand bits.
- The last stage also records the carry into the MSB.
- Outputs are registered and driven from the last stage: out_valid = last-stage valid. Latency is exactly NSTAGE cycles from acceptance to out_valid with no stall.
- Throughput: one beat per cycle while out_ready=1. Results leave in order.
- Saturation (SAT=1, ovf=1):
  - s = 0 followed by all 1s (max positive) when operand A sign is 0;
  - s = 1 followed by all 0s (min negative) when A sign is 1.
  - c_out and ovf still report the raw arithmetic.
- CHUNK == WIDTH degenerates to a single-stage registered adder with latency 1.
- Output hold: while out_valid=1 and out_ready=0, s, c_out, ovf, zero and neg are stable and in_ready=0.
- Accept while draining: a beat presented while out_valid && out_ready is accepted in the same cycle (full throughput, no bubble).
- Reset:
  - all stage valids, out_valid, s, c_out, ovf and neg go to 0, and zero goes to 1 (consistent with s = 0);
  - in_ready = 1 while reset is deasserted and out_valid = 0;
  - asserting rst mid-operation discards all in-flight beats immediately, without waiting for clk.

Test Plan (WIDTH=8, CHUNK=4, SAT=0 unless stated; latency 2):
- Add with no stall: a=0x3C, b=0x0F, ctrl=0, out_ready=1 -> 2 cycles later s=0x4B, c_out=0, ovf=0, zero=0, neg=0.
- Subtract to zero, and borrow: a=0x55, b=0x55, ctrl=1 -> s=0x00, c_out=1, zero=1. Next beat a=0x01, b=0x02, ctrl=1 -> s=0xFF, c_out=0, neg=1.
- Signed overflow and saturation: a=0x7F, b=0x01, ctrl=0 -> SAT=0 gives s=0x80, ovf=1. SAT=1 gives s=0x7F, ovf=1. Also a=0x80, b=0x01, ctrl=1 with SAT=1 -> s=0x80, ovf=1.
- Back-to-back streaming: 16 random beats, in_valid=1, out_ready=1 -> 16 consecutive out_valid cycles, in order, each matching the reference model.
- Backpressure: hold out_ready=0 for 5 cycles with 3 beats in flight -> in_ready=0, outputs stable. Release -> beats emerge in order, with no loss or duplication.
- Asynchronous reset mid-stream: assert rst between clock edges with 2 beats in flight -> out_valid=0 immediately, s=0. After release, the first new beat appears exactly 2 cycles after acceptance.

Source files
------------

// File: rtl/addsub_pipe_if.sv
// Operand/result handshake bundle for the pipelined adder/subtractor.
// The master side produces operands and consumes results; the slave is the pipeline.
interface addsub_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ctrl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             ovf;
  logic             zero;
  logic             neg;

  modport master (
    output in_valid, a, b, ctrl, out_ready,
    input  in_ready, out_valid, s, c_out, ovf, zero, neg
  );

  modport slave (
    input  in_valid, a, b, ctrl, out_ready,
    output in_ready, out_valid, s, c_out, ovf, zero, neg
  );
endinterface

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement add/sub: one CHUNK-bit ripple slice per stage, carry crosses cycles.
// WIDTH must be a multiple of CHUNK and at least 2; latency is WIDTH/CHUNK cycles.
module addsub_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 4,
  parameter bit          SAT   = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  addsub_pipe_if.slave bus
);
  localparam int unsigned NSTAGE = WIDTH / CHUNK;
  localparam int unsigned NPIPE  = (NSTAGE > 1) ? NSTAGE - 1 : 1;
  localparam int unsigned LAST   = NSTAGE - 1;
  localparam int unsigned CW     = CHUNK + 1;
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Stage view: acc holds finished sum bits below the active slice and raw A bits from it upward;
  // bx is B already conditioned for subtract.
  wire [NSTAGE-1:0][WIDTH-1:0] acc_in;
  wire [NSTAGE-1:0][WIDTH-1:0] bx_in;
  wire [NSTAGE-1:0][WIDTH-1:0] sum_w;
  wire [NSTAGE-1:0]            cy_in;
  wire [NSTAGE-1:0]            v_in;
  wire [NSTAGE-1:0]            cy_w;

  logic [NPIPE-1:0][WIDTH-1:0] acc_q;
  logic [NPIPE-1:0][WIDTH-1:0] bx_q;
  logic [NPIPE-1:0]            cy_q;
  logic [NPIPE-1:0]            vld_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] s_q;
  logic             c_out_q;
  logic             ovf_q;
  logic             zero_q;
  logic             neg_q;

  logic             en;
  logic             a_msb;
  logic             bx_msb;
  logic             cin_msb;
  logic             ovf_d;
  logic [WIDTH-1:0] res_d;
  logic             unused_pipe;

  // Whole pipe advances together; a stalled result freezes every stage, bubbles included.
  assign en           = !out_valid_q || bus.out_ready;
  assign bus.in_ready = en;

  assign acc_in[0] = bus.a;
  assign bx_in[0]  = bus.b ^ {WIDTH{bus.ctrl}};
  assign cy_in[0]  = bus.ctrl;
  assign v_in[0]   = bus.in_valid;

  for (genvar k = 1; k < NSTAGE; k++) begin : g_link
    assign acc_in[k] = acc_q[k-1];
    assign bx_in[k]  = bx_q[k-1];
    assign cy_in[k]  = cy_q[k-1];
    assign v_in[k]   = vld_q[k-1];
  end

  for (genvar k = 0; k < NSTAGE; k++) begin : g_slice
    localparam logic [WIDTH-1:0] MASK = WIDTH'({CHUNK{1'b1}}) << (k * CHUNK);
    logic [CW-1:0] slice;

    assign slice = {1'b0, acc_in[k][k*CHUNK +: CHUNK]}
                 + {1'b0, bx_in[k][k*CHUNK +: CHUNK]}
                 + CW'(cy_in[k]);
    assign sum_w[k] = (acc_in[k] & ~MASK) | (WIDTH'(slice[CHUNK-1:0]) << (k * CHUNK));
    assign cy_w[k]  = slice[CHUNK];
  end

  assign a_msb  = acc_in[LAST][WIDTH-1];
  assign bx_msb = bx_in[LAST][WIDTH-1];
  // Sum MSB = a ^ b ^ carry-in, so the carry into the MSB is recovered without a tap.
  assign cin_msb = sum_w[LAST][WIDTH-1] ^ a_msb ^ bx_msb;
  assign ovf_d   = cin_msb ^ cy_w[LAST];

  always_comb begin
    res_d = sum_w[LAST];
    if (SAT && ovf_d) begin
      res_d = a_msb ? MIN_NEG : MAX_POS;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      bx_q  <= '0;
      cy_q  <= '0;
      vld_q <= '0;
    end else if (en) begin
      for (int k = 0; k < int'(LAST); k++) begin
        acc_q[k] <= sum_w[k];
        bx_q[k]  <= bx_in[k];
        cy_q[k]  <= cy_w[k];
        vld_q[k] <= v_in[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      s_q         <= '0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b1;
      neg_q       <= 1'b0;
    end else if (en) begin
      out_valid_q <= v_in[LAST];
      s_q         <= res_d;
      c_out_q     <= cy_w[LAST];
      ovf_q       <= ovf_d;
      zero_q      <= (res_d == '0);
      neg_q       <= res_d[WIDTH-1];
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.s         = s_q;
  assign bus.c_out     = c_out_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;

  // Operand bits below each active slice are carried along but never consumed.
  assign unused_pipe = ^{acc_q, bx_q, cy_q, vld_q};
endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: wrap (SAT=0) and saturating (SAT=1) copies driven in lockstep,
// checked against fixed vectors and an integer-arithmetic reference model.
module tb_addsub_pipe;
  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         ovf;
    logic         zero;
    logic         neg;
  } res_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ctrl;
    logic [W-1:0] s;
    logic         c;
    logic         ovf;
    logic [W-1:0] s_sat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  res_t q0[$];
  res_t q1[$];

  always #5 clk = ~clk;

  addsub_pipe_if #(.WIDTH(W)) bus0 ();
  addsub_pipe_if #(.WIDTH(W)) bus1 ();

  addsub_pipe #(.WIDTH(W), .CHUNK(4), .SAT(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  addsub_pipe #(.WIDTH(W), .CHUNK(4), .SAT(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Exact signed result first, then wrap or clamp; carry from unsigned comparison.
  function automatic res_t model(logic [W-1:0] a, logic [W-1:0] b, logic ctrl, bit sat);
    res_t r;
    int   sa, sb, ua, ub, ex;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    ex = ctrl ? sa - sb : sa + sb;
    r.ovf = (ex > 127) || (ex < -128);
    r.c   = ctrl ? (ua >= ub) : (ua + ub > 255);
    if (sat && ex > 127) ex = 127;
    if (sat && ex < -128) ex = -128;
    r.s    = ex[7:0];
    r.zero = (r.s == 8'h00);
    r.neg  = r.s[7];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ctrl, input logic ordy);
    bus0.in_valid = v;  bus1.in_valid = v;
    bus0.a = a;         bus1.a = a;
    bus0.b = b;         bus1.b = b;
    bus0.ctrl = ctrl;   bus1.ctrl = ctrl;
    bus0.out_ready = ordy;
    bus1.out_ready = ordy;
  endtask

  function automatic logic [31:0] out0();
    return 32'({bus0.s, bus0.c_out, bus0.ovf, bus0.zero, bus0.neg});
  endfunction

  function automatic logic [31:0] out1();
    return 32'({bus1.s, bus1.c_out, bus1.ovf, bus1.zero, bus1.neg});
  endfunction

  // One cycle: scoreboard the current outputs and handshakes, then advance to the next negedge.
  task automatic tick();
    #1;
    if (bus0.out_valid) begin
      check("sb0_pending", 32'(q0.size() != 0), 32'd1);
      if (q0.size() != 0) begin
        check("sb0_data", out0(), 32'(q0[0]));
        if (bus0.out_ready) void'(q0.pop_front());
      end
    end
    if (bus1.out_valid) begin
      check("sb1_pending", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        check("sb1_data", out1(), 32'(q1[0]));
        if (bus1.out_ready) void'(q1.pop_front());
      end
    end
    if (bus0.in_valid && bus0.in_ready) q0.push_back(model(bus0.a, bus0.b, bus0.ctrl, 1'b0));
    if (bus1.in_valid && bus1.in_ready) q1.push_back(model(bus1.a, bus1.b, bus1.ctrl, 1'b1));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 40 && (q0.size() != 0 || q1.size() != 0); i++) tick();
    repeat (3) tick();
    check("drain_q0", 32'(q0.size()), 32'd0);
    check("drain_q1", 32'(q1.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    vecs[0] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0, 8'h4B};
    vecs[1] = '{8'h55, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[2] = '{8'h01, 8'h02, 1'b1, 8'hFF, 1'b0, 1'b0, 8'hFF};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 8'h7F};
    vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 8'h80};
    vecs[5] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 8'h80};

    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("rst_out_valid", 32'(bus0.out_valid), 32'd0);
    check("rst_outputs", out0(), 32'({8'h00, 1'b0, 1'b0, 1'b1, 1'b0}));
    check("rst_sat_outputs", out1(), 32'({8'h00, 1'b0, 1'b0, 1'b1, 1'b0}));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("idle_in_ready", 32'(bus0.in_ready), 32'd1);
    check("idle_out_valid", 32'(bus1.out_valid), 32'd0);
    @(negedge clk);

    // Fixed vectors, one at a time, with exact latency.
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].ctrl, 1'b1);
      tick();
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      check($sformatf("vec%0d_early", i), 32'(bus0.out_valid), 32'd0);
      tick();
      check($sformatf("vec%0d_valid", i), 32'(bus0.out_valid), 32'd1);
      check($sformatf("vec%0d_wrap", i), out0(),
            32'({vecs[i].s, vecs[i].c, vecs[i].ovf, vecs[i].s == 8'h00, vecs[i].s[7]}));
      check($sformatf("vec%0d_sat", i), out1(),
            32'({vecs[i].s_sat, vecs[i].c, vecs[i].ovf, vecs[i].s_sat == 8'h00,
                 vecs[i].s_sat[7]}));
      tick();
    end
    drain();

    // 16 back-to-back beats: out_valid must be high for exactly 16 consecutive cycles.
    for (int i = 0; i < 19; i++) begin
      if (i < 16) drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
      else drive(1'b0, '0, '0, 1'b0, 1'b1);
      #1;
      check($sformatf("stream_valid%0d", i), 32'(bus0.out_valid), 32'(i >= 2 && i < 18));
      tick();
    end
    drain();

    // Backpressure: two beats in the pipe, a third waiting at the input for 5 stalled cycles.
    drive(1'b1, 8'h11, 8'h22, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h90, 8'h05, 1'b1, 1'b0);
    tick();
    drive(1'b1, 8'h7A, 8'h7A, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("bp_in_ready%0d", i), 32'(bus0.in_ready), 32'd0);
      check($sformatf("bp_out_valid%0d", i), 32'(bus0.out_valid), 32'd1);
      check($sformatf("bp_hold%0d", i), out0(), 32'({8'h33, 1'b0, 1'b0, 1'b0, 1'b0}));
      tick();
    end
    drive(1'b1, 8'h7A, 8'h7A, 1'b0, 1'b1);
    #1;
    check("bp_release_ready", 32'(bus0.in_ready), 32'd1);
    tick();
    drain();

    // Random traffic with random backpressure.
    for (int i = 0; i < 120; i++) begin
      drive(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
      tick();
    end
    drain();

    // Asynchronous reset between edges with two beats in flight.
    drive(1'b1, 8'h40, 8'h41, 1'b0, 1'b1);
    tick();
    drive(1'b1, 8'h05, 8'h06, 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    #1;
    check("ar_pre_valid", 32'(bus0.out_valid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("ar_out_valid", 32'(bus0.out_valid), 32'd0);
    check("ar_outputs", out0(), 32'({8'h00, 1'b0, 1'b0, 1'b1, 1'b0}));
    check("ar_sat_valid", 32'(bus1.out_valid), 32'd0);
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 8'h12, 8'h34, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    check("ar_new_early", 32'(bus0.out_valid), 32'd0);
    tick();
    check("ar_new_valid", 32'(bus0.out_valid), 32'd1);
    check("ar_new_data", out0(), 32'({8'h46, 1'b0, 1'b0, 1'b0, 1'b0}));
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
